// File: rtl/ad9252_frame_align.sv
// Alignment controller for the AD9252 LVDS link: bit-slips the deserializers
// until the FCO word is framed, then qualifies every channel on the test pattern.
module ad9252_frame_align #(
    parameter int           NCH           = 8,
    parameter int           W             = 14,
    parameter logic [W-1:0] FRAME_PATTERN = 14'h3F80,
    parameter logic [W-1:0] TEST_PATTERN  = 14'h2AAA,
    parameter int           SETTLE_CYC    = 8,
    parameter int           CHECK_LEN     = 16
) (
    input  logic             clk_adc,
    input  logic             reset,
    input  logic             start,
    input  logic             frame_valid,
    input  logic [W-1:0]     frame_word,
    input  logic [NCH*W-1:0] ch_data,
    output logic             bitslip,
    output logic             data_aligned,
    output logic             align_fail,
    output logic [NCH-1:0]   ch_err,
    output logic [3:0]       slip_cnt,
    output logic [2:0]       state_a
);

    // state       | meaning
    // IDLE        | waiting for start
    // CHECK_FRAME | waiting for a frame to compare against FRAME_PATTERN
    // SLIP        | one-cycle bitslip pulse to every lane
    // SETTLE      | deserializers recovering from the slip; frames ignored
    // CHECK_DATA  | counting consecutive frames with good FCO and test pattern
    // LOCKED      | aligned; only the FCO word is still watched
    // FAIL        | out of slips or channel mismatch; waits for start
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CHECK_FRAME = 3'd1,
        SLIP        = 3'd2,
        SETTLE      = 3'd3,
        CHECK_DATA  = 3'd4,
        LOCKED      = 3'd5,
        FAIL        = 3'd6
    } state_t;

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int MW = $clog2(CHECK_LEN + 1);
    localparam logic [3:0] SLIP_MAX = 4'(W - 1);

    state_t         state;
    logic [SW-1:0]  settle_cnt;
    logic [MW-1:0]  match_cnt;
    logic [NCH-1:0] ch_mis;
    logic           frame_ok;

    assign frame_ok = (frame_word == FRAME_PATTERN);
    assign state_a  = state;

    always_comb begin
        ch_mis = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_mis[i] = (ch_data[i*W +: W] != TEST_PATTERN);
        end
    end

    always_ff @(posedge clk_adc) begin
        if (!reset) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            match_cnt    <= '0;
            slip_cnt     <= '0;
            ch_err       <= '0;
            bitslip      <= 1'b0;
            data_aligned <= 1'b0;
            align_fail   <= 1'b0;
        end else if (start) begin
            state        <= CHECK_FRAME;
            settle_cnt   <= '0;
            match_cnt    <= '0;
            slip_cnt     <= '0;
            ch_err       <= '0;
            bitslip      <= 1'b0;
            data_aligned <= 1'b0;
            align_fail   <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                IDLE: ;
                CHECK_FRAME: begin
                    if (frame_valid) begin
                        if (frame_ok) begin
                            state     <= CHECK_DATA;
                            match_cnt <= '0;
                        end else if (slip_cnt == SLIP_MAX) begin
                            state      <= FAIL;
                            align_fail <= 1'b1;
                        end else begin
                            // pulse and count are raised together so both are seen during SLIP
                            state    <= SLIP;
                            bitslip  <= 1'b1;
                            slip_cnt <= slip_cnt + 4'd1;
                        end
                    end
                end
                SLIP: begin
                    settle_cnt <= SW'(SETTLE_CYC);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= CHECK_FRAME;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CHECK_DATA: begin
                    if (frame_valid) begin
                        if (!frame_ok) begin
                            if (slip_cnt == SLIP_MAX) begin
                                state      <= FAIL;
                                align_fail <= 1'b1;
                            end else begin
                                state    <= SLIP;
                                bitslip  <= 1'b1;
                                slip_cnt <= slip_cnt + 4'd1;
                            end
                        end else if (|ch_mis) begin
                            ch_err     <= ch_err | ch_mis;
                            state      <= FAIL;
                            align_fail <= 1'b1;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == MW'(CHECK_LEN - 1)) begin
                                state        <= LOCKED;
                                data_aligned <= 1'b1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    // channel data is live samples now, so only the FCO word can break lock
                    if (frame_valid && !frame_ok) begin
                        state        <= CHECK_FRAME;
                        data_aligned <= 1'b0;
                        slip_cnt     <= '0;
                    end
                end
                FAIL: align_fail <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9252_frame_align.sv
// Directed bench for ad9252_frame_align: a rotating-lane model feeds frames, a
// per-cycle monitor checks slip accounting/spacing and state-consistent outputs.
module tb_ad9252_frame_align;

    localparam int NCH = 8;
    localparam int W   = 14;
    localparam logic [13:0] FP = 14'h3F80;
    localparam logic [13:0] TP = 14'h2AAA;
    localparam int MIN_GAP = 10;

    logic             clk_adc = 1'b0;
    logic             reset;
    logic             start;
    logic             frame_valid;
    logic [W-1:0]     frame_word;
    logic [NCH*W-1:0] ch_data;
    logic             bitslip;
    logic             data_aligned;
    logic             align_fail;
    logic [NCH-1:0]   ch_err;
    logic [3:0]       slip_cnt;
    logic [2:0]       state_a;

    ad9252_frame_align dut (
        .clk_adc      (clk_adc),
        .reset        (reset),
        .start        (start),
        .frame_valid  (frame_valid),
        .frame_word   (frame_word),
        .ch_data      (ch_data),
        .bitslip      (bitslip),
        .data_aligned (data_aligned),
        .align_fail   (align_fail),
        .ch_err       (ch_err),
        .slip_cnt     (slip_cnt),
        .state_a      (state_a)
    );

    always #5 clk_adc = ~clk_adc;

    int n_checks = 0;
    int n_fail   = 0;

    // lane model: each bitslip rotates every lane back by one bit
    int          init_rot    = 0;
    int          lane_slips  = 0;
    int          total_slips = 0;
    logic        stuck_en    = 1'b0;
    logic [13:0] stuck_val   = '0;
    logic [7:0]  bad_mask    = '0;
    logic [13:0] bad_val     = '0;

    logic mon_en = 1'b0;
    logic start_q = 1'b0, rst_q = 1'b0, da_q = 1'b0;
    int   attempt_slips = 0;
    int   last_slip = -1;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] rotl(input logic [13:0] v, input int k);
        logic [27:0] t;
        t = {v, v} << k;
        return t[27:14];
    endfunction

    function automatic int cur_rot();
        return (((init_rot - lane_slips) % W) + W) % W;
    endfunction

    task automatic send_word(input logic [13:0] fw);
        @(posedge clk_adc);
        #1;
        frame_valid = 1'b1;
        frame_word  = fw;
        for (int i = 0; i < NCH; i++)
            ch_data[i*W +: W] = bad_mask[i] ? bad_val : rotl(TP, cur_rot());
        @(posedge clk_adc);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic send_frame();
        send_word(stuck_en ? stuck_val : rotl(FP, cur_rot()));
    endtask

    task automatic pulse_start();
        @(posedge clk_adc);
        #1 start = 1'b1;
        @(posedge clk_adc);
        #1 start = 1'b0;
    endtask

    task automatic run_frames(input int max_frames);
        int n;
        n = 0;
        while (!(data_aligned || align_fail) && n < max_frames) begin
            send_frame();
            n++;
        end
        check("attempt_done", {31'd0, data_aligned | align_fail}, 32'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk_adc);
            start_q = start;
            rst_q   = reset;
            da_q    = data_aligned;
        end
    end

    // per-cycle consistency against the slip/attempt model
    initial begin
        forever begin
            @(negedge clk_adc);
            cyc++;
            if (mon_en) begin
                if (!rst_q || start_q || (da_q && !data_aligned)) begin
                    attempt_slips = 0;
                    last_slip     = -1;
                end
                if (bitslip) begin
                    lane_slips++;
                    total_slips++;
                    attempt_slips++;
                    check("slip_in_slip_state", {29'd0, state_a}, 32'd2);
                    if (last_slip >= 0) begin
                        n_checks++;
                        if (cyc - last_slip < MIN_GAP) begin
                            n_fail++;
                            $display("FAIL slip_gap: got %0d cycles, expected >= %0d", cyc - last_slip, MIN_GAP);
                        end
                    end
                    last_slip = cyc;
                end
                check("slip_cnt_track", {28'd0, slip_cnt}, attempt_slips);
                check("fail_vs_state", {31'd0, align_fail}, {31'd0, state_a == 3'd6});
                check("aligned_vs_state", {31'd0, data_aligned}, {31'd0, state_a == 3'd5});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n;
        reset = 1'b0; start = 1'b0; frame_valid = 1'b0;
        frame_word = '0; ch_data = '0;
        repeat (3) @(posedge clk_adc);
        #1;
        check("rst_bitslip", {31'd0, bitslip}, 32'd0);
        check("rst_aligned", {31'd0, data_aligned}, 32'd0);
        check("rst_fail", {31'd0, align_fail}, 32'd0);
        check("rst_ch_err", {24'd0, ch_err}, 32'd0);
        check("rst_slip_cnt", {28'd0, slip_cnt}, 32'd0);
        check("rst_state", {29'd0, state_a}, 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // 1: pre-aligned; 1 framing frame then 16 good frames to lock
        init_rot = 0; lane_slips = 0;
        pulse_start();
        s0 = total_slips;
        repeat (16) send_frame();
        check("t1_not_yet", {31'd0, data_aligned}, 32'd0);
        send_frame();
        check("t1_locked", {31'd0, data_aligned}, 32'd1);
        check("t1_state", {29'd0, state_a}, 32'd5);
        check("t1_slips", total_slips - s0, 32'd0);

        // 2: lanes rotated by 5
        init_rot = 5; lane_slips = 0;
        pulse_start();
        s0 = total_slips;
        run_frames(200);
        check("t2_slips", total_slips - s0, 32'd5);
        check("t2_slip_cnt", {28'd0, slip_cnt}, 32'd5);
        check("t2_aligned", {31'd0, data_aligned}, 32'd1);
        check("t2_fail", {31'd0, align_fail}, 32'd0);

        // 3: FCO stuck at zero
        stuck_en = 1'b1; stuck_val = 14'h0000;
        pulse_start();
        s0 = total_slips;
        run_frames(400);
        check("t3_slips", total_slips - s0, 32'd13);
        check("t3_fail", {31'd0, align_fail}, 32'd1);
        check("t3_slip_cnt", {28'd0, slip_cnt}, 32'd13);
        check("t3_aligned", {31'd0, data_aligned}, 32'd0);
        repeat (3) send_frame();
        check("t3_hold_fail", {31'd0, align_fail}, 32'd1);
        check("t3_no_more_slips", total_slips - s0, 32'd13);

        // 4: aligned lanes, ch3 wrong; then ch0+ch7 wrong
        stuck_en = 1'b0; init_rot = 0; lane_slips = 0;
        bad_mask = 8'h08; bad_val = 14'h1555;
        pulse_start();
        check("t4_start_clears_fail", {31'd0, align_fail}, 32'd0);
        check("t4_start_state", {29'd0, state_a}, 32'd1);
        run_frames(100);
        check("t4_ch_err", {24'd0, ch_err}, 32'h08);
        check("t4_fail", {31'd0, align_fail}, 32'd1);
        check("t4_aligned", {31'd0, data_aligned}, 32'd0);
        bad_mask = 8'h81; bad_val = 14'h0000;
        pulse_start();
        check("t4b_start_clears_err", {24'd0, ch_err}, 32'h00);
        run_frames(100);
        check("t4b_ch_err", {24'd0, ch_err}, 32'h81);

        // 5: lock after 2 slips, lose it on one bad FCO, relock
        bad_mask = 8'h00; init_rot = 2; lane_slips = 0;
        pulse_start();
        run_frames(200);
        check("t5_locked", {31'd0, data_aligned}, 32'd1);
        check("t5_slip_cnt", {28'd0, slip_cnt}, 32'd2);
        send_word(14'h3F00);
        check("t5_drop", {31'd0, data_aligned}, 32'd0);
        check("t5_state", {29'd0, state_a}, 32'd1);
        check("t5_slip_clr", {28'd0, slip_cnt}, 32'd0);
        s0 = total_slips;
        run_frames(100);
        check("t5_relock", {31'd0, data_aligned}, 32'd1);
        check("t5_relock_slips", total_slips - s0, 32'd0);

        // 6a: reset in the middle of SETTLE
        init_rot = 3; lane_slips = 0;
        pulse_start();
        s0 = total_slips; n = 0;
        while (total_slips == s0 && n < 50) begin
            send_frame();
            n++;
        end
        repeat (2) @(posedge clk_adc);
        #1;
        check("t6_in_settle", {29'd0, state_a}, 32'd3);
        reset = 1'b0;
        @(posedge clk_adc);
        #1;
        check("t6_rst_state", {29'd0, state_a}, 32'd0);
        check("t6_rst_slip_cnt", {28'd0, slip_cnt}, 32'd0);
        check("t6_rst_outs", {28'd0, bitslip, data_aligned, align_fail, 1'b0}, 32'd0);
        check("t6_rst_ch_err", {24'd0, ch_err}, 32'd0);
        reset = 1'b1;
        repeat (2) send_frame();
        check("t6_idle_holds", {29'd0, state_a}, 32'd0);

        // 6b: restart from CHECK_DATA (lanes still need 2 slips)
        pulse_start();
        n = 0;
        while (state_a != 3'd4 && n < 100) begin
            send_frame();
            n++;
        end
        repeat (3) send_frame();
        check("t6b_pre_slip_cnt", {28'd0, slip_cnt}, 32'd2);
        pulse_start();
        check("t6b_slip_clr", {28'd0, slip_cnt}, 32'd0);
        check("t6b_ch_err", {24'd0, ch_err}, 32'd0);
        check("t6b_state", {29'd0, state_a}, 32'd1);
        repeat (16) send_frame();
        check("t6b_not_yet", {31'd0, data_aligned}, 32'd0);
        send_frame();
        check("t6b_locked", {31'd0, data_aligned}, 32'd1);

        repeat (2) @(posedge clk_adc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
